// File: rtl/inexact_mul_seq.sv
// inexact_mul_seq: sequences the four nibble products of an 8x8 multiply through one shared 4x4 approximate multiplier
module inexact_mul_seq #(
    parameter int unsigned MUL_LAT   = 0,
    parameter bit          LL_AP3    = 1'b1,
    parameter bit          SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod8,
    output logic        mul_en,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    output logic        mul_var,
    input  logic [7:0]  mul_prod,
    output logic        busy
);
    localparam int WW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
    typedef enum logic [1:0] {IDLE, STEP, ACC, DONE} state_t;
    state_t        r_state;
    logic [7:0]    r_a, r_b;
    logic [1:0]    r_k;
    logic [WW-1:0] r_wait;
    logic [7:0]    r_pp [4];
    logic [1:0]    w_nk;
    logic [3:0]    w_na, w_nb;
    logic          w_skip, w_nskip, w_askip, w_step_done;
    logic [16:0]   w_sum;
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    // next-step nibble selection (k[1] picks the a nibble, k[0] the b nibble), skip decisions and the shift-add
    always_comb begin
        w_nk        = r_k + 2'd1;
        w_na        = w_nk[1] ? r_a[7:4] : r_a[3:0];
        w_nb        = w_nk[0] ? r_b[7:4] : r_b[3:0];
        w_skip      = SKIP_ZERO && (mul_a == 4'd0 || mul_b == 4'd0);
        w_nskip     = SKIP_ZERO && (w_na == 4'd0 || w_nb == 4'd0);
        w_askip     = SKIP_ZERO && (a[3:0] == 4'd0 || b[3:0] == 4'd0);
        w_step_done = w_skip || (r_wait == WW'(MUL_LAT));
        w_sum       = {9'd0, r_pp[0]} + {5'd0, r_pp[1], 4'd0} + {5'd0, r_pp[2], 4'd0} + {1'b0, r_pp[3], 8'd0};
    end
    // control FSM: accept operands, issue/capture each nibble step, accumulate, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_wait  <= '0;
            r_pp    <= '{default: '0};
            prod8   <= '0;
            mul_en  <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_var <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_k     <= 2'd0;
                    r_wait  <= '0;
                    mul_a   <= a[3:0];
                    mul_b   <= b[3:0];
                    mul_var <= LL_AP3;
                    mul_en  <= !w_askip;
                    r_state <= STEP;
                end
                STEP: begin
                    mul_en <= 1'b0;
                    if (w_step_done) begin
                        r_pp[r_k] <= w_skip ? 8'd0 : mul_prod;
                        r_wait    <= '0;
                        if (r_k == 2'd3) begin
                            r_state <= ACC;
                        end else begin
                            r_k     <= w_nk;
                            mul_a   <= w_na;
                            mul_b   <= w_nb;
                            mul_var <= 1'b0;
                            mul_en  <= !w_nskip;
                        end
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                ACC: begin
                    prod8   <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
                    r_state <= DONE;
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inexact_mul_seq.sv
// tb_inexact_mul_seq: directed bench with a transaction-level reference model for two multiplier latencies
module tb_inexact_mul_seq;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stub_ff = 1'b0;
    logic [1:0]        iv, ir, ov, ordy, me, mv, bz;
    logic [1:0][7:0]   ia, ib, mprod;
    logic [1:0][3:0]   ma, mb;
    logic [1:0][15:0]  prod;
    logic [7:0]        pipe1, pipe2;
    int                n_vec = 0, n_err = 0;
    bit                m_live = 0;
    int                m_ph [2], m_idx [2], m_len [2];
    logic [15:0]       m_prod [2], m_exp [2];
    logic [3:0]        m_ma [2], m_mb [2];
    logic              m_mv [2];
    logic [9:0]        m_sch [2][16];

    always #5 clk = ~clk;

    inexact_mul_seq #(.MUL_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(ia[0]), .b(ib[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .prod8(prod[0]), .mul_en(me[0]), .mul_a(ma[0]),
        .mul_b(mb[0]), .mul_var(mv[0]), .mul_prod(mprod[0]), .busy(bz[0]));
    inexact_mul_seq #(.MUL_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(ia[1]), .b(ib[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .prod8(prod[1]), .mul_en(me[1]), .mul_a(ma[1]),
        .mul_b(mb[1]), .mul_var(mv[1]), .mul_prod(mprod[1]), .busy(bz[1]));

    // multiplier stubs: exact combinational (or forced 0xFF) for dut0, exact with two-cycle delay for dut2
    assign mprod[0] = stub_ff ? 8'hFF : {4'd0, ma[0]} * {4'd0, mb[0]};
    always @(posedge clk) begin
        pipe1 <= {4'd0, ma[1]} * {4'd0, mb[1]};
        pipe2 <= pipe1;
    end
    assign mprod[1] = pipe2;

    task automatic chk(string nm, int d, logic [15:0] act, logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d]: got %h expected %h", nm, d, act, exp);
        end
    endtask

    // expand one transaction into its per-cycle step list and its expected product
    task automatic build(int d, logic [7:0] x, logic [7:0] y);
        int n, lat, p;
        logic [3:0] na, nb;
        logic [16:0] sum;
        n = 0;
        sum = 0;
        lat = (d == 0) ? 0 : 2;
        for (int k = 0; k < 4; k++) begin
            na = (k >= 2) ? x[7:4] : x[3:0];
            nb = (k % 2 == 1) ? y[7:4] : y[3:0];
            if (na == 0 || nb == 0) begin
                m_sch[d][n] = {1'b0, k == 0, na, nb};
                n++;
                p = 0;
            end else begin
                for (int j = 0; j <= lat; j++) begin
                    m_sch[d][n] = {j == 0, k == 0, na, nb};
                    n++;
                end
                p = (d == 0 && stub_ff) ? 255 : int'(na) * int'(nb);
            end
            sum += 17'(p) << ((k == 0) ? 0 : (k == 3) ? 8 : 4);
        end
        m_len[d] = n;
        m_exp[d] = sum[16] ? 16'hFFFF : sum[15:0];
    endtask

    // reference model: advances on each clock from the bench-driven inputs only
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_live = 1;
                m_ph[d] = 0;
                m_prod[d] = 0;
                m_ma[d] = 0;
                m_mb[d] = 0;
                m_mv[d] = 0;
                m_idx[d] = 0;
            end else if (m_ph[d] == 0) begin
                if (iv[d]) begin
                    build(d, ia[d], ib[d]);
                    m_ph[d] = 1;
                    m_idx[d] = 0;
                    {m_mv[d], m_ma[d], m_mb[d]} = m_sch[d][0][8:0];
                end
            end else if (m_ph[d] == 1) begin
                m_idx[d]++;
                if (m_idx[d] == m_len[d]) m_ph[d] = 2;
                else {m_mv[d], m_ma[d], m_mb[d]} = m_sch[d][m_idx[d]][8:0];
            end else if (m_ph[d] == 2) begin
                m_prod[d] = m_exp[d];
                m_ph[d] = 3;
            end else if (ordy[d]) begin
                m_ph[d] = 0;
            end
        end
    end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_live) begin
            for (int d = 0; d < 2; d++) begin
                chk("in_ready", d, 16'(ir[d]), 16'(m_ph[d] == 0));
                chk("busy", d, 16'(bz[d]), 16'(m_ph[d] != 0));
                chk("out_valid", d, 16'(ov[d]), 16'(m_ph[d] == 3));
                chk("prod8", d, prod[d], m_prod[d]);
                chk("mul_en", d, 16'(me[d]), 16'((m_ph[d] == 1) ? m_sch[d][m_idx[d]][9] : 1'b0));
                chk("mul_a", d, 16'(ma[d]), 16'(m_ma[d]));
                chk("mul_b", d, 16'(mb[d]), 16'(m_mb[d]));
                chk("mul_var", d, 16'(mv[d]), 16'(m_mv[d]));
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(int d, logic [7:0] x, logic [7:0] y, logic [15:0] exp, int lat);
        int cnt;
        iv[d] = 1'b1;
        ia[d] = x;
        ib[d] = y;
        ordy[d] = 1'b1;
        tick();
        iv[d] = 1'b0;
        chk("first_var", d, 16'(mv[d]), 16'd1);
        cnt = 1;
        while (!ov[d] && cnt < 60) begin
            tick();
            cnt++;
        end
        chk("latency", d, 16'(cnt), 16'(lat));
        chk("result", d, prod[d], exp);
        chk("model_result", d, m_prod[d], exp);
        tick();
    endtask

    initial begin
        int cnt;
        iv = '0;
        ordy = '0;
        ia = '0;
        ib = '0;
        tick(2);
        rst = 1'b0;
        chk("rst_in_ready", 0, 16'(ir[0]), 16'd1);
        chk("rst_prod8", 0, prod[0], 16'h0000);
        chk("rst_busy", 0, 16'(bz[0]), 16'd0);
        tick();
        run(0, 8'hFF, 8'hFF, 16'hFE01, 6);
        run(0, 8'h10, 8'h01, 16'h0010, 6);
        stub_ff = 1'b1;
        run(0, 8'h11, 8'h11, 16'hFFFF, 6);
        stub_ff = 1'b0;
        // backpressure with an ignored second request
        iv[0] = 1'b1;
        ia[0] = 8'h12;
        ib[0] = 8'h34;
        ordy[0] = 1'b0;
        tick();
        iv[0] = 1'b0;
        cnt = 1;
        while (!ov[0] && cnt < 60) begin
            tick();
            cnt++;
        end
        chk("bp_latency", 0, 16'(cnt), 16'd6);
        iv[0] = 1'b1;
        ia[0] = 8'h55;
        ib[0] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_prod", 0, prod[0], 16'h03A8);
            chk("bp_hold_ready", 0, 16'(ir[0]), 16'd0);
            tick();
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        chk("bp_release_ready", 0, 16'(ir[0]), 16'd1);
        chk("bp_release_valid", 0, 16'(ov[0]), 16'd0);
        tick();
        // two-cycle multiplier latency
        run(1, 8'h23, 8'h45, 16'h096F, 14);
        // reset during the HL step
        iv[0] = 1'b1;
        ia[0] = 8'h77;
        ib[0] = 8'h77;
        tick();
        iv[0] = 1'b0;
        tick(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 0, 16'(bz[0]), 16'd0);
        chk("mid_rst_in_ready", 0, 16'(ir[0]), 16'd1);
        chk("mid_rst_out_valid", 0, 16'(ov[0]), 16'd0);
        chk("mid_rst_mul_en", 0, 16'(me[0]), 16'd0);
        run(0, 8'h02, 8'h03, 16'h0006, 6);
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
